lector_contadores: RTL and testbench



---
 rtl/lector_contadores.sv | 113 +++++++++++
 tb/tb_lector_contadores.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lector_contadores.sv
// Sweep reader for the four per-FIFO word counters: requests idx 0..3 in order, snapshots
// each returned value into a bank and pulses done; a per-request timeout keeps the sweep finite.
module lector_contadores #(
  parameter int CNT_WIDTH = 5,
  parameter int TIMEOUT   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 IDLE,
  input  logic                 valid_contador,
  input  logic [CNT_WIDTH-1:0] contador_in,
  output logic                 req,
  output logic [1:0]           idx,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1,
  output logic [CNT_WIDTH-1:0] cnt2,
  output logic [CNT_WIDTH-1:0] cnt3,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [1:0] {REPOSO, PIDE, RECIBE, LISTO} state_t;

  localparam logic [3:0] T_LAST = 4'(TIMEOUT - 1);

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_idx;
  logic [CNT_WIDTH-1:0] r_bank [4];
  logic                 r_error;
  logic [3:0]           r_timer;
  logic                 w_timeout;
  logic                 w_step;

  // A response arriving on the last timer cycle still wins over the timeout.
  assign w_timeout = (r_state == RECIBE) && !valid_contador && (r_timer == T_LAST);
  assign w_step    = (r_state == RECIBE) && (valid_contador || w_timeout);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= REPOSO;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    req    = 1'b0;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      REPOSO: begin
        busy = 1'b0;
        if (start) w_next = PIDE;
      end
      PIDE: begin
        req = IDLE;
        if (IDLE) w_next = RECIBE;
      end
      RECIBE: begin
        if (w_step) w_next = (r_idx == 2'd3) ? LISTO : PIDE;
      end
      LISTO: begin
        done   = 1'b1;
        w_next = REPOSO;
      end
      default: w_next = REPOSO;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx   <= 2'd0;
      r_error <= 1'b0;
      r_timer <= 4'd0;
      for (int i = 0; i < 4; i++) r_bank[i] <= '0;
    end else begin
      case (r_state)
        REPOSO: begin
          if (start) begin
            r_idx   <= 2'd0;
            r_error <= 1'b0;
            r_timer <= 4'd0;
          end
        end
        PIDE: begin
          if (IDLE) r_timer <= 4'd0;
        end
        RECIBE: begin
          if (valid_contador) begin
            r_bank[r_idx] <= contador_in;
          end else if (w_timeout) begin
            r_bank[r_idx] <= '0;
            r_error       <= 1'b1;
          end else begin
            r_timer <= r_timer + 4'd1;
          end
          // idx stops at 3 so it still names the last counter after the sweep.
          if (w_step && (r_idx != 2'd3)) r_idx <= r_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign idx   = r_idx;
  assign error = r_error;
  assign cnt0  = r_bank[0];
  assign cnt1  = r_bank[1];
  assign cnt2  = r_bank[2];
  assign cnt3  = r_bank[3];

endmodule

// File: tb/tb_lector_contadores.sv
// Bench for lector_contadores: a responder model answers each req one cycle later and a
// scoreboard of expected bank entries is checked when done pulses.
module tb_lector_contadores;

  localparam int CW = 5;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          IDLE;
  logic          valid_contador;
  logic [CW-1:0] contador_in;
  logic          req;
  logic [1:0]    idx;
  logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;
  logic          busy;
  logic          done;
  logic          error;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int idx;
    int val;
  } exp_t;

  exp_t sb[$];

  lector_contadores #(.CNT_WIDTH(CW), .TIMEOUT(8)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .start          (start),
    .IDLE           (IDLE),
    .valid_contador (valid_contador),
    .contador_in    (contador_in),
    .req            (req),
    .idx            (idx),
    .cnt0           (cnt0),
    .cnt1           (cnt1),
    .cnt2           (cnt2),
    .cnt3           (cnt3),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int get_cnt(input int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      2:       return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  // One sweep: start pulse, then a cycle loop that drives IDLE/start/responses at each
  // negedge and samples outputs 1 ns later. Cycle c=1 is the cycle after the start edge.
  task automatic run_sweep(input int v0, input int v1, input int v2, input int v3,
                           input int miss, input int idle_low,
                           input int restart1, input int restart2,
                           input int exp_done, input int exp_err);
    int   vals[4];
    int   ndone;
    int   done_cyc;
    int   nreq;
    int   pidx;
    logic pend;
    exp_t e;
    vals     = '{v0, v1, v2, v3};
    sb.delete();
    ndone    = 0;
    done_cyc = -1;
    nreq     = 0;
    pidx     = 0;
    pend     = 1'b0;
    @(negedge clk);
    start = 1'b1;
    IDLE  = (idle_low == 0);
    for (int c = 1; c <= exp_done + 3; c++) begin
      @(negedge clk);
      start          = (c == restart1) || (c == restart2);
      IDLE           = (c > idle_low);
      valid_contador = pend;
      contador_in    = pend ? CW'(vals[pidx]) : '0;
      #1;
      if (c == 1) begin
        chk("error_cleared_at_start", int'(error), 0);
        chk("busy_in_sweep", int'(busy), 1);
      end
      if (c <= idle_low) chk("req_gated_by_idle", int'(req), 0);
      pend = 1'b0;
      if (req) begin
        chk("idx_sequence", int'(idx), nreq);
        e.idx = int'(idx);
        e.val = (int'(idx) == miss) ? 0 : vals[int'(idx)];
        sb.push_back(e);
        pend = (int'(idx) != miss);
        pidx = int'(idx);
        nreq++;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
        chk("sb_size", sb.size(), 4);
        while (sb.size() > 0) begin
          e = sb.pop_front();
          chk("bank_entry", get_cnt(e.idx), e.val);
        end
      end
    end
    valid_contador = 1'b0;
    contador_in    = '0;
    chk("done_cycle", done_cyc, exp_done);
    chk("done_pulses", ndone, 1);
    chk("req_count", nreq, 4);
    chk("error_flag", int'(error), exp_err);
    chk("busy_after", int'(busy), 0);
    chk("idx_holds_3", int'(idx), 3);
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    IDLE           = 1'b0;
    valid_contador = 1'b0;
    contador_in    = '0;
    #12;
    chk("rst_req", int'(req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_idx", int'(idx), 0);
    chk("rst_cnt0", int'(cnt0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // nominal
    run_sweep(3, 7, 0, 31, -1, 0, 0, 0, 9, 0);
    // IDLE low for 4 cycles
    run_sweep(9, 1, 30, 2, -1, 4, 0, 0, 13, 0);
    // idx 2 never answers
    run_sweep(5, 12, 17, 25, 2, 0, 0, 0, 16, 1);
    // back-to-back: cnt0 moves 5 -> 6, previous error cleared
    run_sweep(6, 12, 17, 25, -1, 0, 0, 0, 9, 0);
    // start re-pulsed while busy and in LISTO
    run_sweep(4, 8, 15, 16, -1, 0, 3, 9, 9, 0);

    // asynchronous reset mid-sweep, between edges
    @(negedge clk);
    start = 1'b1;
    IDLE  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt0", int'(cnt0), 0);
    chk("mid_rst_cnt1", int'(cnt1), 0);
    chk("mid_rst_cnt2", int'(cnt2), 0);
    chk("mid_rst_cnt3", int'(cnt3), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_req", int'(req), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_idx", int'(idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(1, 2, 3, 4, -1, 0, 0, 0, 9, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
